rr_arb16: RTL and testbench
===========================

# rr_arb16

Round-robin arbiter sharing one word-wide output channel among 16 requesters. Each cycle it picks at most one requesting source, selects that source's word through the 16-way utility word mux, and registers it into a single-entry valid/ready output stage. Requesters may lock the channel for bounded bursts. It sits in front of any shared single-port resource in the CPU, such as a bus port, register-file write port or memory port.

## Interface
- `n`, default `constants::WORD_LENGTH`: width of each data word in bits.
- `BURST_MAX`, default 4: maximum consecutive beats one locked requester may take before rotation is forced. Legal range 1..15; 1 disables locking.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset_n`  in  1: synchronous reset, active-low, sampled on the `clk` rising edge.
- `req`  in  16: `req[i]` means requester i has a valid word on `in[i]`.
- `lock`  in  16: `lock[i]` requests that requester i keep priority after its current beat. Only meaningful while `req[i]` is high.
- `in`  in  n x 16 (unpacked `[n-1:0] in [15:0]`): per-requester data words.
- `gnt`  out  16: one-hot or zero, combinational. `gnt[i]` means `in[i]` is captured at this rising edge.
- `out`  out  n: registered word.
- `out_valid`  out  1: `out` holds an unconsumed word.
- `out_ready`  in  1: consumer accepts `out` this cycle.
- `sel`  out  4: registered index of the requester whose word is in `out`.

## Operation
- State registers:
  - `out_valid`, `out`, `sel`
  - `ptr[3:0]`: highest-priority index
  - `last[3:0]`: last winner
  - `cnt[3:0]`: consecutive beats granted to `last`
- Load condition: `load = (|req) && (!out_valid || out_ready)`.
- Winner `w` is the first index with `req` set, scanning `ptr, ptr+1, … , ptr+15` mod 16. `gnt = load ? onehot(w) : 0`.
- On load:
  - `out <= in[w]`, `sel <= w`, `out_valid <= 1`.
  - `newcnt = (w == last && cnt < BURST_MAX) ? cnt+1 : 1`. Then `cnt <= newcnt` and `last <= w`.
  - If `lock[w] && newcnt < BURST_MAX`, then `ptr <= w` (w keeps top priority).
  - Otherwise `ptr <= w+1` mod 16 (15 wraps to 0).
- If `out_valid && out_ready && !(|req)`: `out_valid <= 0`. `out`, `sel`, `ptr`, `last` and `cnt` hold.
- If `out_valid && !out_ready`: everything holds and `gnt` is 0. The requester keeps `req` and `in` stable until granted.
- Requester protocol:
  - A requester asserts `req[i]` and holds `in[i]` until the cycle `gnt[i]` is 1.
  - Next cycle it may drop `req`, or present the next word with `req` still high.
  - Dropping `req` before grant is allowed (withdrawal). The arbiter never grants an index whose `req` is low.
- Effective two-state machine on `out_valid`:
  - EMPTY (0) goes to FULL on load.
  - FULL (1) stays FULL when load (back-to-back).
  - FULL goes to EMPTY on `out_ready && !(|req)`.
  - FULL holds when `!out_ready`.
- Fairness: with all `lock` low, every continuously requesting source is granted within 16 loads. With locks, the wait is within 16 x `BURST_MAX` loads.

## Timing
- Reset (`reset_n` low at a rising edge): `out_valid=0`, `out=0`, `sel=0`, `ptr=0`, `last=0`, `cnt=0`. `gnt` evaluates to 0 while `reset_n` is low, regardless of `req`.
- Reset mid-operation discards any held word with no handshake. The first cycle after reset release may load immediately.
- Latency: word captured at edge k (`gnt` high in cycle k) appears on `out` with `out_valid=1` in cycle k+1.
- Throughput: 1 word/cycle while `out_ready=1` and `req` is nonzero.
- `gnt` depends combinationally on `req`, `ptr`, `out_valid` and `out_ready`. It has no path from `in` or `lock`.
- A simultaneous consume and load in one cycle is legal: the old word is consumed and the new word is registered at the same edge.

## Test plan
- Reset: hold `reset_n=0` with `req=16'hFFFF` → `gnt=0`, `out_valid=0`, `sel=0`, `out=0`. Release with `req=16'h0001`, `in[0]=5` → `gnt=16'h0001` in that cycle; next cycle `out=5`, `out_valid=1`, `sel=0`.
- Full rotation: `req=16'hFFFF`, `lock=0`, `out_ready=1` for 17 cycles, `in[i]=i+100` → `sel` sequence 0,1,…,15,0; `out` sequence 100…115,100; `gnt` is always one-hot.
- Backpressure: FULL with `sel=3`, `out_ready=0` for 5 cycles, `req=16'h0030` → `gnt=0` and `out`/`sel` stable. After `out_ready=1` → grant 4, then 5.
- Locked burst: `BURST_MAX=4`, `req=16'h0006`, `lock=16'h0002`, `ptr=1`, `out_ready=1` → `sel` sequence 1,1,1,1,2,1,1,1,1,2.
- Drain and wrap: single `req[15]` for one beat then `req=0`, `out_ready=1` → `sel=15`, then `out_valid` drops. Next `req=16'h8001` → winner 0 (`ptr` wrapped to 0).
- Reset mid-burst: locked burst at `cnt=2` with `out_valid=1`, then pulse `reset_n=0` → all registers return to reset values and the burst restarts from `ptr=0`.

Source files
------------

// File: rtl/rr_arb16.sv
// ---------------------------------------------------------------------------
// rr_arb16 - round-robin arbiter with a single-entry registered output.
//
// Sixteen requesters share one word-wide output channel. Each cycle the
// arbiter grants at most one requesting source. The granted word goes through
// a 16-way word mux and is registered into a one-deep valid/ready stage.
// A requester may hold lock high to keep top priority for a bounded burst of
// BURST_MAX consecutive beats. After that, rotation moves on.
//
// Parameters
//   n          word width in bits
//   BURST_MAX  maximum consecutive locked beats (1..15); 1 disables locking
//
// Ports
//   clk        clock, rising edge
//   reset_n    synchronous reset, active low
//   req[15:0]  per-requester valid
//   lock[15:0] per-requester "keep priority after this beat"
//   in[15:0]   per-requester data words
//   gnt[15:0]  combinational one-hot grant (zero when nothing loads)
//   out        registered word
//   out_valid  out holds an unconsumed word
//   out_ready  consumer accepts out this cycle
//   sel        registered index of the requester whose word is in out
// ---------------------------------------------------------------------------

package constants;
  localparam int unsigned WORD_LENGTH = 32;
endpackage

// 16-way word mux used to steer the winning requester's word.
module word_mux16 #(
  parameter int unsigned n = constants::WORD_LENGTH
) (
  input  logic [n-1:0] in [15:0],
  input  logic [3:0]   sel_i,
  output logic [n-1:0] out_o
);
  always_comb out_o = in[sel_i];
endmodule

module rr_arb16 #(
  parameter int unsigned n         = constants::WORD_LENGTH,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [15:0]  req,
  input  logic [15:0]  lock,
  input  logic [n-1:0] in [15:0],
  output logic [15:0]  gnt,
  output logic [n-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   sel
);

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  // State
  logic         valid_q, valid_d;
  logic [n-1:0] out_q,   out_d;
  logic [3:0]   sel_q,   sel_d;
  logic [3:0]   ptr_q,   ptr_d;
  logic [3:0]   last_q,  last_d;
  logic [3:0]   cnt_q,   cnt_d;

  // Arbitration
  logic [31:0]  req_dbl;
  logic [15:0]  req_rot;
  logic [3:0]   off;
  logic [3:0]   win;
  logic         load;
  logic [3:0]   newcnt;
  logic [n-1:0] win_word;

  // Rotate the request vector so that bit 0 is the current top-priority
  // index. The first set bit then gives the offset of the winner from ptr.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[ptr_q +: 16];

  always_comb begin
    off = '0;
    for (int j = 15; j >= 0; j--) begin
      if (req_rot[j]) off = 4'(j);
    end
  end

  // The 4-bit add wraps modulo 16.
  assign win  = ptr_q + off;
  assign load = (|req) && (!valid_q || out_ready);

  // The grant is gated by reset so it never announces a capture that reset
  // would discard.
  assign gnt = (load && reset_n) ? (16'h0001 << win) : 16'h0000;

  // Burst counting: beats only accumulate while the same index keeps
  // winning and the cap has not been hit. Anything else starts a new run.
  assign newcnt = (win == last_q && cnt_q < BMAX) ? cnt_q + 4'd1 : 4'd1;

  word_mux16 #(.n(n)) u_mux (
    .in    (in),
    .sel_i (win),
    .out_o (win_word)
  );

  always_comb begin
    valid_d = valid_q;
    out_d   = out_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (load) begin
      valid_d = 1'b1;
      out_d   = win_word;
      sel_d   = win;
      cnt_d   = newcnt;
      last_d  = win;
      // A locked winner keeps top priority until its burst reaches the cap.
      // Otherwise priority moves to the next index.
      if (lock[win] && newcnt < BMAX) ptr_d = win;
      else                            ptr_d = win + 4'd1;
    end else if (valid_q && out_ready) begin
      // This is a consume with nothing new to load. The slot empties and
      // the arbitration state holds.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign sel       = sel_q;

endmodule

// File: tb/tb_rr_arb16.sv
// ---------------------------------------------------------------------------
// tb_rr_arb16 - directed vector bench for rr_arb16.
//
// Each table row drives inputs for one cycle. gnt is checked before the
// rising edge. out_valid, sel and out are checked just after the edge.
// Data words are in[i] = base + i. The rows run as one continuous sequence,
// so each row's expectation depends on the state left by the rows before it.
// ---------------------------------------------------------------------------
module tb_rr_arb16;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [15:0]  req = '0;
  logic [15:0]  lock = '0;
  logic [W-1:0] din [15:0];
  logic [15:0]  gnt;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [3:0]   sel;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_arb16 #(.n(W), .BURST_MAX(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .lock      (lock),
    .in        (din),
    .gnt       (gnt),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel       (sel)
  );

  typedef struct {
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] lock;
    logic        rdy;
    int          base;
    logic [15:0] egnt;
    logic        evld;
    logic [3:0]  esel;
    logic [31:0] eout;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [15:0] rq, input logic [15:0] lk,
                     input logic rd, input int base, input logic [15:0] eg,
                     input logic ev, input logic [3:0] es, input logic [31:0] eo);
    vec_t v;
    v.rst_n = r; v.req = rq; v.lock = lk; v.rdy = rd; v.base = base;
    v.egnt = eg; v.evld = ev; v.esel = es; v.eout = eo;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_words(input int base);
    for (int i = 0; i < 16; i++) din[i] = 32'(base + i);
  endtask

  initial begin
    int s;
    logic [15:0] g;
    int burst[10];
    burst = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    set_words(5);

    // Reset holds gnt low even with every requester active.
    add(0, 16'hFFFF, 0, 1, 5, 16'h0000, 0, 0, 0);
    add(0, 16'hFFFF, 0, 1, 5, 16'h0000, 0, 0, 0);
    // The first cycle after release loads immediately.
    add(1, 16'h0001, 0, 1, 5, 16'h0001, 1, 0, 5);
    // Reset again so the rotation starts from ptr=0.
    add(0, 16'h0000, 0, 1, 100, 16'h0000, 0, 0, 0);
    // Full rotation: 0..15 then 0.
    for (int i = 0; i < 17; i++) begin
      s = i % 16;
      g = 16'h0001 << s;
      add(1, 16'hFFFF, 0, 1, 100, g, 1, 4'(s), 32'(100 + s));
    end
    // Get to FULL with sel=3, then apply backpressure for 5 cycles.
    add(1, 16'h0008, 0, 1, 100, 16'h0008, 1, 3, 103);
    for (int i = 0; i < 5; i++) add(1, 16'h0030, 0, 0, 100, 16'h0000, 1, 3, 103);
    add(1, 16'h0030, 0, 1, 100, 16'h0010, 1, 4, 104);
    add(1, 16'h0030, 0, 1, 100, 16'h0020, 1, 5, 105);
    // Drain and wrap: 15 wins, the slot empties, then ptr=0 picks 0 over 15.
    add(1, 16'h8000, 0, 1, 100, 16'h8000, 1, 15, 115);
    add(1, 16'h0000, 0, 1, 100, 16'h0000, 0, 15, 115);
    add(1, 16'h8001, 0, 1, 100, 16'h0001, 1, 0, 100);
    // Locked burst from ptr=1: 1,1,1,1,2,1,1,1,1,2.
    for (int i = 0; i < 10; i++) begin
      s = burst[i];
      g = 16'h0001 << s;
      add(1, 16'h0006, 16'h0002, 1, 100, g, 1, 4'(s), 32'(100 + s));
    end
    // Two beats into a new burst, then reset. The burst must restart fresh.
    add(1, 16'h0006, 16'h0002, 1, 100, 16'h0002, 1, 1, 101);
    add(1, 16'h0006, 16'h0002, 1, 100, 16'h0002, 1, 1, 101);
    add(0, 16'h0006, 16'h0002, 1, 100, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      s = burst[i];
      g = 16'h0001 << s;
      add(1, 16'h0006, 16'h0002, 1, 100, g, 1, 4'(s), 32'(100 + s));
    end

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      reset_n   = vq[k].rst_n;
      req       = vq[k].req;
      lock      = vq[k].lock;
      out_ready = vq[k].rdy;
      set_words(vq[k].base);
      #1;
      chk($sformatf("v%0d gnt", k), 32'(gnt), 32'(vq[k].egnt));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(vq[k].evld));
      chk($sformatf("v%0d sel", k), 32'(sel), 32'(vq[k].esel));
      chk($sformatf("v%0d out", k), out, vq[k].eout);
    end

    // Hand sequence: gnt follows out_ready combinationally and ignores lock
    // and in. The state is FULL (sel=2) with ptr=3.
    @(negedge clk);
    req = 16'h0001; lock = 16'h0000; out_ready = 1'b0;
    #1 chk("hand gnt stalled", 32'(gnt), 32'h0);
    out_ready = 1'b1;
    #1 chk("hand gnt on ready", 32'(gnt), 32'h0001);
    lock = 16'hFFFF; set_words(200);
    #1 chk("hand gnt ignores lock/in", 32'(gnt), 32'h0001);
    @(posedge clk); #1;
    chk("hand sel", 32'(sel), 32'd0);
    chk("hand out", out, 32'd200);
    // Locked index 0 keeps priority over 1 on the next beat.
    @(negedge clk);
    req = 16'h0003;
    #1 chk("hand locked gnt", 32'(gnt), 32'h0001);
    @(posedge clk); #1;
    chk("hand locked sel", 32'(sel), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
